// File: rtl/sc_regbank_modal_if.sv
// Command/status bundle for sc_regbank_modal.
// Latency: n/a (wires only); mode/sel/data/serial are sampled by the bank on the clock edge.
// Backpressure: none; the bank accepts one command every cycle.
//
// Ports (modport slave = register bank, master = controlling logic):
//   SC_RegBANK_mode_InBUS   3-bit command (hold/load/clear/inc/dec/shl/shr/lock)
//   SC_RegBANK_sel_InBUS    target channel
//   SC_RegBANK_data_InBUS   load data, bit 0 doubles as lock value
//   SC_RegBANK_serial_In    fill bit for shifts
//   SC_RegBANK_data_OutBUS  selected channel value
//   SC_RegBANK_all_OutBUS   all channels, channel 0 in LSBs
//   SC_RegBANK_zero_Out     selected channel is zero
//   SC_RegBANK_locked_Out   lock bit of selected channel
//   SC_RegBANK_carry_Out    one-cycle wrap pulse
//   SC_RegBANK_serial_Out   last bit shifted out
interface sc_regbank_modal_if #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int SELWIDTH      = 2
);
    logic [2:0]                            SC_RegBANK_mode_InBUS;
    logic [SELWIDTH-1:0]                   SC_RegBANK_sel_InBUS;
    logic [DATAWIDTH_BUS-1:0]              SC_RegBANK_data_InBUS;
    logic                                  SC_RegBANK_serial_In;
    logic [DATAWIDTH_BUS-1:0]              SC_RegBANK_data_OutBUS;
    logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] SC_RegBANK_all_OutBUS;
    logic                                  SC_RegBANK_zero_Out;
    logic                                  SC_RegBANK_locked_Out;
    logic                                  SC_RegBANK_carry_Out;
    logic                                  SC_RegBANK_serial_Out;

    modport master (
        output SC_RegBANK_mode_InBUS, SC_RegBANK_sel_InBUS,
               SC_RegBANK_data_InBUS, SC_RegBANK_serial_In,
        input  SC_RegBANK_data_OutBUS, SC_RegBANK_all_OutBUS, SC_RegBANK_zero_Out,
               SC_RegBANK_locked_Out, SC_RegBANK_carry_Out, SC_RegBANK_serial_Out
    );

    modport slave (
        input  SC_RegBANK_mode_InBUS, SC_RegBANK_sel_InBUS,
               SC_RegBANK_data_InBUS, SC_RegBANK_serial_In,
        output SC_RegBANK_data_OutBUS, SC_RegBANK_all_OutBUS, SC_RegBANK_zero_Out,
               SC_RegBANK_locked_Out, SC_RegBANK_carry_Out, SC_RegBANK_serial_Out
    );
endinterface

// File: rtl/sc_regbank_modal.sv
// Multi-channel register bank; each channel modified by a 3-bit mode command with per-channel lock.
// Latency: command takes effect on the sampling edge; data/zero/locked outputs are combinational from the registers.
// Backpressure: none; one command accepted every cycle, back-to-back with no bubbles.
//
// Ports:
//   SC_RegFIXED_CLOCK_50      rising-edge clock
//   SC_RegFIXED_RESET_InHigh  asynchronous active-high reset (channels -> INIT, locks/flags -> 0)
//   rb                        command/status bundle (slave side), see sc_regbank_modal_if
module sc_regbank_modal #(
    parameter int                       DATAWIDTH_BUS      = 8,
    parameter int                       NUM_CHANNELS       = 4,
    parameter int                       SELWIDTH           = 2,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT = '0
) (
    input  logic                SC_RegFIXED_CLOCK_50,
    input  logic                SC_RegFIXED_RESET_InHigh,
    sc_regbank_modal_if.slave   rb
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_LOAD  = 3'd1,
        MODE_CLEAR = 3'd2,
        MODE_INC   = 3'd3,
        MODE_DEC   = 3'd4,
        MODE_SHL   = 3'd5,
        MODE_SHR   = 3'd6,
        MODE_LOCK  = 3'd7
    } mode_e;

    logic [DATAWIDTH_BUS-1:0] ch_q [NUM_CHANNELS];
    logic [DATAWIDTH_BUS-1:0] ch_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  lock_q, lock_d;
    logic                     carry_q, carry_d;
    logic                     serial_q, serial_d;

    logic [DATAWIDTH_BUS-1:0] cur, nxt;
    logic                     cur_lock, sel_hit, wr_en, lock_wr;
    mode_e                    mode;

    // Channel select decode. Comparing against every implemented index (rather than
    // indexing with sel) makes out-of-range selects read as zero/unlocked and never
    // touch an array element that does not exist.
    always_comb begin
        cur      = '0;
        cur_lock = 1'b0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rb.SC_RegBANK_sel_InBUS == SELWIDTH'(i)) begin
                cur      = ch_q[i];
                cur_lock = lock_q[i];
                sel_hit  = 1'b1;
            end
        end
    end

    // Command decode. Carry is a pulse, so it defaults low every cycle; serial out
    // holds unless an honoured shift replaces it.
    always_comb begin
        mode     = mode_e'(rb.SC_RegBANK_mode_InBUS);
        nxt      = cur;
        wr_en    = 1'b0;
        lock_wr  = 1'b0;
        carry_d  = 1'b0;
        serial_d = serial_q;
        if (sel_hit) begin
            if (mode == MODE_LOCK) begin
                // Always honoured so a locked channel can be released.
                lock_wr = 1'b1;
            end else if (!cur_lock) begin
                case (mode)
                    MODE_LOAD: begin
                        nxt   = rb.SC_RegBANK_data_InBUS;
                        wr_en = 1'b1;
                    end
                    MODE_CLEAR: begin
                        nxt   = DATA_REGFIXED_INIT;
                        wr_en = 1'b1;
                    end
                    MODE_INC: begin
                        nxt     = cur + DATAWIDTH_BUS'(1);
                        carry_d = &cur;
                        wr_en   = 1'b1;
                    end
                    MODE_DEC: begin
                        nxt     = cur - DATAWIDTH_BUS'(1);
                        carry_d = ~|cur;
                        wr_en   = 1'b1;
                    end
                    MODE_SHL: begin
                        nxt      = {cur[DATAWIDTH_BUS-2:0], rb.SC_RegBANK_serial_In};
                        serial_d = cur[DATAWIDTH_BUS-1];
                        wr_en    = 1'b1;
                    end
                    MODE_SHR: begin
                        nxt      = {rb.SC_RegBANK_serial_In, cur[DATAWIDTH_BUS-1:1]};
                        serial_d = cur[0];
                        wr_en    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        ch_d   = ch_q;
        lock_d = lock_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rb.SC_RegBANK_sel_InBUS == SELWIDTH'(i)) begin
                if (wr_en)   ch_d[i]   = nxt;
                if (lock_wr) lock_d[i] = rb.SC_RegBANK_data_InBUS[0];
            end
        end
    end

    always_ff @(posedge SC_RegFIXED_CLOCK_50 or posedge SC_RegFIXED_RESET_InHigh) begin
        if (SC_RegFIXED_RESET_InHigh) begin
            for (int i = 0; i < NUM_CHANNELS; i++) ch_q[i] <= DATA_REGFIXED_INIT;
            lock_q   <= '0;
            carry_q  <= 1'b0;
            serial_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) ch_q[i] <= ch_d[i];
            lock_q   <= lock_d;
            carry_q  <= carry_d;
            serial_q <= serial_d;
        end
    end

    assign rb.SC_RegBANK_data_OutBUS = cur;
    assign rb.SC_RegBANK_zero_Out    = (cur == '0);
    assign rb.SC_RegBANK_locked_Out  = cur_lock;
    assign rb.SC_RegBANK_carry_Out   = carry_q;
    assign rb.SC_RegBANK_serial_Out  = serial_q;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_all
        assign rb.SC_RegBANK_all_OutBUS[g*DATAWIDTH_BUS +: DATAWIDTH_BUS] = ch_q[g];
    end

endmodule

// File: tb/tb_sc_regbank_modal.sv
module tb_sc_regbank_modal;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_regbank_modal_if #(.DATAWIDTH_BUS(8), .NUM_CHANNELS(4), .SELWIDTH(2)) bus_a ();
    sc_regbank_modal_if #(.DATAWIDTH_BUS(8), .NUM_CHANNELS(3), .SELWIDTH(2)) bus_b ();

    sc_regbank_modal #(
        .DATAWIDTH_BUS(8), .NUM_CHANNELS(4), .SELWIDTH(2), .DATA_REGFIXED_INIT(8'hA5)
    ) dut_a (
        .SC_RegFIXED_CLOCK_50    (clk),
        .SC_RegFIXED_RESET_InHigh(rst),
        .rb                      (bus_a)
    );

    sc_regbank_modal #(
        .DATAWIDTH_BUS(8), .NUM_CHANNELS(3), .SELWIDTH(2), .DATA_REGFIXED_INIT(8'h00)
    ) dut_b (
        .SC_RegFIXED_CLOCK_50    (clk),
        .SC_RegFIXED_RESET_InHigh(rst),
        .rb                      (bus_b)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit cmp_en  = 1'b0;

    // Behavioural model of the 4-channel bank: plain integers per channel.
    int m_ch [4];
    bit m_lock [4];
    bit m_carry;
    bit m_serial;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_ch[i]   = 165;
            m_lock[i] = 1'b0;
        end
        m_carry  = 1'b0;
        m_serial = 1'b0;
    endtask

    task automatic model_step(input int mode, input int s, input int d, input int si);
        int v;
        m_carry = 1'b0;
        if (s >= 4) return;
        if (mode == 7) begin
            m_lock[s] = (d % 2) == 1;
            return;
        end
        if (mode == 0 || m_lock[s]) return;
        v = m_ch[s];
        case (mode)
            1: v = d % 256;
            2: v = 165;
            3: begin m_carry = (v == 255); v = (v + 1) % 256; end
            4: begin m_carry = (v == 0);   v = (v + 255) % 256; end
            5: begin m_serial = (v / 128) == 1; v = (v * 2) % 256 + si; end
            6: begin m_serial = (v % 2) == 1;   v = v / 2 + si * 128; end
            default: ;
        endcase
        m_ch[s] = v;
    endtask

    // Per-cycle comparison of the 4-channel DUT against the model, away from the active edge.
    always @(negedge clk) begin
        int s;
        logic [31:0] ea;
        if (cmp_en) begin
            s  = int'(bus_a.SC_RegBANK_sel_InBUS);
            ea = '0;
            for (int i = 0; i < 4; i++) ea[8*i +: 8] = 8'(m_ch[i]);
            chk("cyc_data",   32'(bus_a.SC_RegBANK_data_OutBUS), 32'(m_ch[s]));
            chk("cyc_zero",   32'(bus_a.SC_RegBANK_zero_Out),    32'(m_ch[s] == 0));
            chk("cyc_locked", 32'(bus_a.SC_RegBANK_locked_Out),  32'(m_lock[s]));
            chk("cyc_carry",  32'(bus_a.SC_RegBANK_carry_Out),   32'(m_carry));
            chk("cyc_serial", 32'(bus_a.SC_RegBANK_serial_Out),  32'(m_serial));
            chk("cyc_all",    bus_a.SC_RegBANK_all_OutBUS,       ea);
        end
    end

    // Drive one command on bank A, let it be sampled, return at posedge+1.
    task automatic cmd(input int mode, input int s, input int d, input int si);
        bus_a.SC_RegBANK_mode_InBUS = 3'(mode);
        bus_a.SC_RegBANK_sel_InBUS  = 2'(s);
        bus_a.SC_RegBANK_data_InBUS = 8'(d);
        bus_a.SC_RegBANK_serial_In  = 1'(si);
        @(posedge clk);
        if (!rst) model_step(mode, s, d, si);
        #1;
    endtask

    // Drive bank B while bank A idles with HOLD.
    task automatic cmd_b(input int mode, input int s, input int d);
        bus_b.SC_RegBANK_mode_InBUS = 3'(mode);
        bus_b.SC_RegBANK_sel_InBUS  = 2'(s);
        bus_b.SC_RegBANK_data_InBUS = 8'(d);
        cmd(0, 0, 0, 0);
    endtask

    // Commands checked only through the model.
    int tbl_mode [10] = '{1, 5, 5, 6, 3, 4, 7, 6, 7, 2};
    int tbl_sel  [10] = '{3, 3, 3, 3, 1, 2, 1, 1, 1, 3};
    int tbl_dat  [10] = '{8'h5A, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int tbl_si   [10] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        bus_a.SC_RegBANK_mode_InBUS = 3'd0;
        bus_a.SC_RegBANK_sel_InBUS  = 2'd0;
        bus_a.SC_RegBANK_data_InBUS = 8'd0;
        bus_a.SC_RegBANK_serial_In  = 1'b0;
        bus_b.SC_RegBANK_mode_InBUS = 3'd0;
        bus_b.SC_RegBANK_sel_InBUS  = 2'd0;
        bus_b.SC_RegBANK_data_InBUS = 8'd0;
        bus_b.SC_RegBANK_serial_In  = 1'b0;
        model_reset();
        rst    = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_all",    bus_a.SC_RegBANK_all_OutBUS, 32'hA5A5A5A5);
        chk("rst_carry",  32'(bus_a.SC_RegBANK_carry_Out),  32'd0);
        chk("rst_serial", 32'(bus_a.SC_RegBANK_serial_Out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_a.SC_RegBANK_sel_InBUS = 2'(i);
            #1 chk("rst_locked", 32'(bus_a.SC_RegBANK_locked_Out), 32'd0);
        end

        // Increment wrap
        cmd(1, 2, 8'hFF, 0);
        cmd(3, 2, 0, 0);
        chk("inc_data",  32'(bus_a.SC_RegBANK_data_OutBUS), 32'h00);
        chk("inc_zero",  32'(bus_a.SC_RegBANK_zero_Out),    32'd1);
        chk("inc_carry", 32'(bus_a.SC_RegBANK_carry_Out),   32'd1);
        chk("inc_all",   bus_a.SC_RegBANK_all_OutBUS,       32'hA500A5A5);
        cmd(0, 2, 0, 0);
        chk("carry_pulse_end", 32'(bus_a.SC_RegBANK_carry_Out), 32'd0);

        // Shifts
        cmd(1, 1, 8'b1000_0001, 0);
        cmd(5, 1, 0, 0);
        chk("shl_data",   32'(bus_a.SC_RegBANK_data_OutBUS), 32'b0000_0010);
        chk("shl_serial", 32'(bus_a.SC_RegBANK_serial_Out),  32'd1);
        cmd(6, 1, 0, 1);
        chk("shr_data",   32'(bus_a.SC_RegBANK_data_OutBUS), 32'b1000_0001);
        chk("shr_serial", 32'(bus_a.SC_RegBANK_serial_Out),  32'd0);

        // Lock / unlock, back-to-back
        cmd(7, 3, 1, 0);
        cmd(1, 3, 8'h3C, 0);
        chk("lock_data",   32'(bus_a.SC_RegBANK_data_OutBUS), 32'hA5);
        chk("lock_locked", 32'(bus_a.SC_RegBANK_locked_Out),  32'd1);
        cmd(7, 3, 0, 0);
        cmd(1, 3, 8'h3C, 0);
        chk("unlock_data", 32'(bus_a.SC_RegBANK_data_OutBUS), 32'h3C);

        // Decrement wrap, and a locked channel must not wrap or flag
        cmd(1, 0, 8'h00, 0);
        cmd(4, 0, 0, 0);
        chk("dec_data",  32'(bus_a.SC_RegBANK_data_OutBUS), 32'hFF);
        chk("dec_carry", 32'(bus_a.SC_RegBANK_carry_Out),   32'd1);
        cmd(7, 0, 1, 0);
        cmd(3, 0, 0, 0);
        chk("lockinc_data",  32'(bus_a.SC_RegBANK_data_OutBUS), 32'hFF);
        chk("lockinc_carry", 32'(bus_a.SC_RegBANK_carry_Out),   32'd0);
        cmd(7, 0, 0, 0);
        cmd(2, 0, 0, 0);
        chk("clear_data", 32'(bus_a.SC_RegBANK_data_OutBUS), 32'hA5);

        for (int i = 0; i < 10; i++) cmd(tbl_mode[i], tbl_sel[i], tbl_dat[i], tbl_si[i]);

        // Asynchronous reset between INC commands
        cmd(3, 1, 0, 0);
        cmd(3, 1, 0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_all",    bus_a.SC_RegBANK_all_OutBUS, 32'hA5A5A5A5);
        chk("arst_carry",  32'(bus_a.SC_RegBANK_carry_Out),  32'd0);
        chk("arst_serial", 32'(bus_a.SC_RegBANK_serial_Out), 32'd0);
        chk("arst_locked", 32'(bus_a.SC_RegBANK_locked_Out), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmd(3, 1, 0, 0);
        chk("post_rst_inc", 32'(bus_a.SC_RegBANK_data_OutBUS), 32'hA6);

        // Three-channel bank: select 3 is out of range
        cmd_b(1, 0, 8'h11);
        cmd_b(1, 2, 8'h22);
        cmd_b(1, 3, 8'h55);
        cmd_b(7, 3, 1);
        chk("b_all",    32'(bus_b.SC_RegBANK_all_OutBUS),  32'h220011);
        chk("b_data3",  32'(bus_b.SC_RegBANK_data_OutBUS), 32'h00);
        chk("b_zero3",  32'(bus_b.SC_RegBANK_zero_Out),    32'd1);
        chk("b_lock3",  32'(bus_b.SC_RegBANK_locked_Out),  32'd0);
        bus_b.SC_RegBANK_sel_InBUS = 2'd2;
        #1 chk("b_sel2_comb", 32'(bus_b.SC_RegBANK_data_OutBUS), 32'h22);

        cmd(0, 0, 0, 0);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
